// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment frame reader: segment patterns
// (bit6=a ... bit0=g), the invalid-BCD marker and the stability FSM encoding.
package sevenseg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

  localparam logic [BCD_W-1:0] BCD_INVALID = 4'hF;

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] bcd;
  } dec_t;

endpackage

// File: rtl/sevenseg_frame_reader_decoder.sv
// Combinational inverse of the BCD-to-segment table; unknown patterns
// decode to BCD_INVALID with valid cleared.
module seg_pattern_decoder
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output dec_t             dec_c
);

  always_comb begin
    dec_c = '{valid: 1'b1, bcd: 4'd0};
    case (seg)
      SEG_0:   dec_c.bcd = 4'd0;
      SEG_1:   dec_c.bcd = 4'd1;
      SEG_2:   dec_c.bcd = 4'd2;
      SEG_3:   dec_c.bcd = 4'd3;
      SEG_4:   dec_c.bcd = 4'd4;
      SEG_5:   dec_c.bcd = 4'd5;
      SEG_6:   dec_c.bcd = 4'd6;
      SEG_7:   dec_c.bcd = 4'd7;
      SEG_8:   dec_c.bcd = 4'd8;
      SEG_9:   dec_c.bcd = 4'd9;
      default: dec_c = '{valid: 1'b0, bcd: BCD_INVALID};
    endcase
  end

endmodule

// File: rtl/sevenseg_frame_reader.sv
// Samples a multiplexed seven-segment bus, debounces each digit and assembles
// N-digit BCD frames on a valid/ready port. SEG_ACTIVE_LOW_EN inverts inputs.
module sevenseg_frame_reader
  import sevenseg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] frame_digits,
  output logic                  frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  bad_pattern,
  output logic                  overrun
);

  localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FRAME_W = BCD_W * N_DIGITS;

  logic [SEG_W-1:0]    seg_q1, seg_q2, prev_seg_q, s_seg;
  logic [N_DIGITS-1:0] an_q1, an_q2, prev_an_q, s_an;
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept_c, qual_c, same_c, complete_c;
  logic [IDX_W-1:0]    idx_c;
  dec_t                dec_c;
  logic [FRAME_W-1:0]  shadow_q;
  logic [N_DIGITS-1:0] captured_q;
  logic                err_flag_q;

  // Two-flop synchronizers plus the previous-sample register for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q1     <= '0;
      seg_q2     <= '0;
      an_q1      <= '0;
      an_q2      <= '0;
      prev_seg_q <= '0;
      prev_an_q  <= '0;
    end else begin
      seg_q1     <= seg_in;
      seg_q2     <= seg_q1;
      an_q1      <= an_in;
      an_q2      <= an_q1;
      prev_seg_q <= s_seg;
      prev_an_q  <= s_an;
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign s_seg = ~seg_q2;
  assign s_an  = ~an_q2;
`else
  assign s_seg = seg_q2;
  assign s_an  = an_q2;
`endif

  assign qual_c     = (s_an != '0) && ((s_an & (s_an - N_DIGITS'(1))) == '0);
  assign same_c     = ({s_seg, s_an} == {prev_seg_q, prev_an_q});
  assign complete_c = &captured_q;

  always_comb begin
    idx_c = '0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (s_an[i]) idx_c = IDX_W'(i);
    end
  end

  seg_pattern_decoder u_dec (
    .seg   (s_seg),
    .dec_c (dec_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Accept fires on the edge where the run of identical samples reaches STABLE_CYCLES
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (qual_c && same_c) begin
          if (cnt_q == CNT_W'(STABLE_CYCLES - 2)) begin
            accept_c = 1'b1;
            state_d  = ST_LOCKED;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (!qual_c || !same_c) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame assembly and output handshake; a same-cycle accept starts the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= {N_DIGITS{BCD_INVALID}};
      captured_q   <= '0;
      err_flag_q   <= 1'b0;
      frame_digits <= '0;
      frame_err    <= 1'b0;
      frame_valid  <= 1'b0;
      bad_pattern  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      bad_pattern <= accept_c && !dec_c.valid;
      overrun     <= 1'b0;
      if (accept_c) shadow_q[{idx_c, 2'b00} +: BCD_W] <= dec_c.bcd;

      if (complete_c) begin
        captured_q <= accept_c ? (N_DIGITS'(1) << idx_c) : '0;
        err_flag_q <= accept_c && !dec_c.valid;
      end else if (accept_c) begin
        captured_q[idx_c] <= 1'b1;
        if (!dec_c.valid) err_flag_q <= 1'b1;
      end

      if (complete_c && (!frame_valid || frame_ready)) begin
        frame_digits <= shadow_q;
        frame_err    <= err_flag_q;
        frame_valid  <= 1'b1;
      end else begin
        if (complete_c) overrun <= 1'b1;
        if (frame_ready) frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sevenseg_frame_reader.md
Name: sevenseg_frame_reader

Overview:
- Receive side of the multiplexed seven-segment interface: samples segment lines and one-hot digit strobes from a display driver.
- Filters them for stability and inverts the segment encoding back to BCD, one digit per strobe.
- Assembles a complete N-digit frame and presents it on a valid/ready output.
- Used for loopback self-test of display paths and for reading external 7-segment panels.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a digit is accepted (2..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- seg_in  input  7  segment lines, bit6=a ... bit0=g, active-high; asynchronous to clk
- an_in  input  N_DIGITS  digit strobes, active-high, bit i = digit i; asynchronous to clk
- frame_digits  output  4*N_DIGITS  BCD frame, digit i at [4i+3:4i]
- frame_err  output  1  frame contains at least one undecodable digit
- frame_valid  output  1  frame available
- frame_ready  input  1  consumer accepts frame
- bad_pattern  output  1  one-cycle pulse on acceptance of an undecodable pattern
- overrun  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset state: all outputs 0, shadow digits 4'hF, captured vector 0, FSM in WAIT, counter 0.
- Synchronization:
  - seg_in and an_in pass through 2-flop synchronizers.
  - All logic below uses the synchronized values s_seg and s_an.
- Stability FSM, states WAIT and LOCKED:
  - Sample qualifies when s_an is exactly one-hot.
  - WAIT: counter increments while the sample qualifies and {s_seg,s_an} equals the previous cycle's value; any change or non-qualifying sample sets counter to 0.
  - WAIT to LOCKED: when counter reaches STABLE_CYCLES-1, the digit is accepted that cycle.
  - LOCKED: no further accepts. Returns to WAIT with counter 0 on any change of {s_seg,s_an}.
  - s_an all-zero or multi-hot: always WAIT, counter 0.
- Decode, inverse of the team's BCD-to-segment table:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011.
  - Any other pattern gives 4'hF, pulses bad_pattern and sets the frame error flag.
- On accept:
  - shadow[idx] <= decoded value; captured[idx] <= 1.
  - A re-accept of the same idx within a frame overwrites it (last value wins).
- Frame completion: registered captured == all ones. In that cycle captured clears and the frame error flag clears.
  - An accept in the same cycle lands in the new, cleared frame.
  - If !frame_valid or frame_ready: frame_digits <= shadow, frame_err <= flag, frame_valid <= 1.
  - Otherwise the frame is dropped, output unchanged, overrun pulses one cycle.
- Handshake:
  - frame_valid stays high, and frame_digits and frame_err stay stable, until a cycle with frame_ready=1.
  - That cycle frame_valid drops, unless a new frame loads in the same cycle; then it stays 1 with new data.
  - frame_ready while !frame_valid has no effect.
- Latency: a stable input is accepted STABLE_CYCLES+2 clk edges after it appears at the pins; frame_valid rises 1 cycle after the final digit's accept.
- rst_n assertion mid-frame discards partial captures and any pending frame immediately.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: seg_in and an_in are inverted after the synchronizers, for common-anode panels; all other behaviour is unchanged.
- Undefined: inputs are active-high as specified above.

Decomposition:
- Package sevenseg_pkg holds:
  - segment constants SEG_0..SEG_9;
  - BCD_INVALID = 4'hF;
  - state encoding for WAIT/LOCKED.
- Sub-module seg_pattern_decoder: combinational 7-bit pattern to {valid, bcd[3:0]}, using the package constants.

Test Plan:
- Drive an_in=0001,0010,0100,1000 in turn, each held 10 cycles, with segs 1111110,0110000,1101101,1111001 -> frame_valid=1, frame_digits=16'h3210, frame_err=0.
- Digit 2 with seg 0000001 -> bad_pattern pulses once, frame digit 2 = F, frame_err=1.
- Toggle seg_in every 2 cycles with STABLE_CYCLES=4 -> no accepts, no frame. Hold stable 4 synced cycles -> exactly one accept.
- frame_ready held 0 across two full frames -> first frame held unchanged, overrun pulses once at second completion. Then frame_ready=1 for one cycle -> frame_valid drops.
- an_in=0011 for 20 cycles -> no accept, counter stays 0.
- rst_n low after 3 digits are captured -> all outputs 0. After release, a full 4-digit scan is needed before frame_valid.
